// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the core's 4-bit opcode map.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned AMT_W     = 5;

    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_AND = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL = 4'h7;
    localparam logic [OP_W-1:0] OP_ROR = 4'h8;
    localparam logic [OP_W-1:0] OP_ROL = 4'h9;
    localparam logic [OP_W-1:0] OP_NOT = 4'hA;
    localparam logic [OP_W-1:0] OP_MUL = 4'hB;
    localparam logic [OP_W-1:0] OP_JEQ = 4'hC;
    localparam logic [OP_W-1:0] OP_JNE = 4'hD;
    localparam logic [OP_W-1:0] OP_JMP = 4'hE;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator shared by the four shift and rotate opcodes.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir_left,
    input  logic             rotate,
    output logic [WIDTH-1:0] result_c
);

    logic [2*WIDTH-1:0] dbl_c;
    logic [AMT_W-1:0]   rot_amt_c;
    logic               over_c;

    // Rotates work on a doubled copy of the data; plain shifts saturate to zero past WIDTH.
    always_comb begin
        dbl_c     = '0;
        result_c  = '0;
        rot_amt_c = AMT_W'(32'(amount) % WIDTH);
        over_c    = (32'(amount) >= WIDTH);
        if (rotate) begin
            if (dir_left) begin
                dbl_c    = {data, data} << rot_amt_c;
                result_c = dbl_c[2*WIDTH-1:WIDTH];
            end else begin
                dbl_c    = {data, data} >> rot_amt_c;
                result_c = dbl_c[WIDTH-1:0];
            end
        end else if (!over_c) begin
            result_c = dir_left ? (data << amount) : (data >> amount);
        end
    end

endmodule : alu_shifter

// File: rtl/alu.sv
// Registered 16-bit ALU: one-cycle latency, full throughput, flags derived from each new result.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_en,
    input  logic [OP_W-1:0]  oper,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             carry,
    output logic             zero,
    output logic             neg
);

    logic [WIDTH-1:0]   q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     diff_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   shift_res_c;
    logic [WIDTH-1:0]   res_c;
    logic               cout_c;
    logic               sh_left_c;
    logic               sh_rot_c;

    // Shift direction and mode decoded from the opcode.
    always_comb begin
        sh_left_c = (oper == OP_SHL) || (oper == OP_ROL);
        sh_rot_c  = (oper == OP_ROR) || (oper == OP_ROL);
    end

    alu_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .data     (operandA),
        .amount   (operandB[AMT_W-1:0]),
        .dir_left (sh_left_c),
        .rotate   (sh_rot_c),
        .result_c (shift_res_c)
    );

    // Opcode datapath; non-ALU opcodes yield zero with no carry.
    always_comb begin
        sum_c  = {1'b0, operandA} + {1'b0, operandB};
        diff_c = {1'b0, operandA} - {1'b0, operandB};
        prod_c = (2*WIDTH)'(operandA) * (2*WIDTH)'(operandB);
        res_c  = '0;
        cout_c = 1'b0;
        case (oper)
            OP_ADD: begin
                res_c  = sum_c[WIDTH-1:0];
                cout_c = sum_c[WIDTH];
            end
            OP_SUB: begin
                res_c  = diff_c[WIDTH-1:0];
                cout_c = diff_c[WIDTH];
            end
            OP_AND: res_c = operandA & operandB;
            OP_OR:  res_c = operandA | operandB;
            OP_XOR: res_c = operandA ^ operandB;
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: res_c = shift_res_c;
            OP_NOT: res_c = ~operandA;
            OP_MUL: begin
                res_c  = prod_c[WIDTH-1:0];
                cout_c = |prod_c[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    // Next-state: capture result and flags on alu_en, otherwise hold; q_valid follows alu_en.
    always_comb begin
        q_d       = q_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        q_valid_d = alu_en;
        if (alu_en) begin
            q_d     = res_c;
            carry_d = cout_c;
            zero_d  = (res_c == '0);
            neg_d   = res_c[WIDTH-1];
        end
    end

    // Output register stage with synchronous reset taking priority over alu_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign neg     = neg_q;

endmodule : alu

// File: tb/tb_alu.sv
// Directed self-checking bench for alu using an expected-result scoreboard queue.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic         c;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         alu_en;
    logic [3:0]   oper;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [W-1:0] q;
    logic         q_valid;
    logic         carry;
    logic         zero;
    logic         neg;

    exp_t sb[$];
    int   n_checks;
    int   n_fails;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_en   (alu_en),
        .oper     (oper),
        .operandA (operandA),
        .operandB (operandB),
        .q        (q),
        .q_valid  (q_valid),
        .carry    (carry),
        .zero     (zero),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [W-1:0] eq, input logic ec, input logic ev);
        chk({tag, ".q"},     32'(q),       32'(eq));
        chk({tag, ".carry"}, 32'(carry),   32'(ec));
        chk({tag, ".zero"},  32'(zero),    32'(eq == '0));
        chk({tag, ".neg"},   32'(neg),     32'(eq[W-1]));
        chk({tag, ".valid"}, 32'(q_valid), 32'(ev));
    endtask

    // Drive one operation, push its expectation, then compare the popped entry one edge later.
    task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic ec);
        exp_t e;
        @(negedge clk);
        alu_en   = 1'b1;
        oper     = op;
        operandA = a;
        operandB = b;
        sb.push_back('{q: eq, c: ec});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk_flags(tag, e.q, e.c, 1'b1);
        end
    endtask

    // Drop alu_en with fresh operands and check the outputs hold.
    task automatic hold(input string tag, input logic [W-1:0] eq, input logic ec);
        @(negedge clk);
        alu_en   = 1'b0;
        oper     = 4'($urandom_range(0, 15));
        operandA = W'($urandom);
        operandB = W'($urandom);
        @(posedge clk);
        #1;
        chk_flags(tag, eq, ec, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        alu_en   = 1'b1;
        oper     = OP_ADD;
        operandA = 16'h0005;
        operandB = 16'h0006;

        // Reset held with a pending ADD.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_flags("reset", 16'h0000, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst    = 1'b0;
        alu_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_flags("post_reset", 16'h0000, 1'b0, 1'b0);
        end

        // Arithmetic.
        issue("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        issue("add_neg",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        issue("sub_borrow",OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1);
        hold ("hold_carry", 16'hFFFE, 1'b1);
        issue("sub_plain", OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b0);
        issue("mul_ovf",   OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1);
        issue("mul_small", OP_MUL, 16'h0012, 16'h0003, 16'h0036, 1'b0);

        // Logic.
        issue("and", OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
        issue("or",  OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0);
        issue("xor", OP_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0);
        issue("not", OP_NOT, 16'hF0F0, 16'h3C3C, 16'h0F0F, 1'b0);

        // Shift and rotate.
        issue("shr1",    OP_SHR, 16'h8001, 16'h0001, 16'h4000, 1'b0);
        issue("shl1",    OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b0);
        issue("ror1",    OP_ROR, 16'h8001, 16'h0001, 16'hC000, 1'b0);
        issue("rol1",    OP_ROL, 16'h8001, 16'h0001, 16'h0003, 1'b0);
        issue("shl16",   OP_SHL, 16'h8001, 16'h0010, 16'h0000, 1'b0);
        issue("shr16",   OP_SHR, 16'h8001, 16'h0010, 16'h0000, 1'b0);
        issue("shr15",   OP_SHR, 16'h8001, 16'h000F, 16'h0001, 1'b0);
        issue("rol17",   OP_ROL, 16'h8001, 16'h0011, 16'h0003, 1'b0);
        issue("ror16",   OP_ROR, 16'h8001, 16'h0010, 16'h8001, 1'b0);
        issue("shr_hiB", OP_SHR, 16'h8001, 16'hFFE1, 16'h4000, 1'b0);

        // Back-to-back throughput then hold.
        issue("b2b_add", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0);
        issue("b2b_xor", OP_XOR, 16'h0005, 16'h0005, 16'h0000, 1'b0);
        issue("b2b_shl", OP_SHL, 16'h0001, 16'h0004, 16'h0010, 1'b0);
        hold ("hold1", 16'h0010, 1'b0);
        hold ("hold2", 16'h0010, 1'b0);

        // Non-ALU opcodes after a nonzero result.
        issue("op_jmp", OP_JMP, 16'h1234, 16'h5678, 16'h0000, 1'b0);
        issue("add_nz", OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b1);
        issue("op_0",   4'h0,   16'h1234, 16'h5678, 16'h0000, 1'b0);

        // Operation accepted just before reset is discarded.
        issue("pre_rst", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        alu_en   = 1'b1;
        oper     = OP_ADD;
        operandA = 16'h0011;
        operandB = 16'h0022;
        @(posedge clk);
        #1;
        chk_flags("rst_prio", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        alu_en = 1'b0;
        @(posedge clk);
        #1;
        chk_flags("rst_release", 16'h0000, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_alu
